// File: rtl/piso_serializer_if.sv
// Parallel-load / serial-out bus between a word source and the serializer.
// The master side drives the load strobe and word; the slave side returns the shift state.
interface piso_serializer_if #(
    parameter int DATA_WIDTH = 9
);
    logic                  load;
    logic [DATA_WIDTH-1:1] x;
    logic [DATA_WIDTH-1:1] y;
    logic                  z;
    logic                  busy;

    modport master (
        output load,
        output x,
        input  y,
        input  z,
        input  busy
    );

    modport slave (
        input  load,
        input  x,
        output y,
        output z,
        output busy
    );
endinterface

// File: rtl/piso_serializer.sv
// LSB-first parallel-in/serial-out shift register for the transmit path.
// A load captures a (DATA_WIDTH-1)-bit word, which is then shifted out one bit per clock.
module piso_serializer #(
    parameter int DATA_WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    piso_serializer_if.slave         bus
);
    localparam int W     = DATA_WIDTH - 1;
    localparam int CNT_W = $clog2(W + 1);

    logic [DATA_WIDTH-1:1] sr_q;
    logic [DATA_WIDTH-1:1] sr_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;

    // cnt holds the number of word bits still to appear on z, so busy is simply cnt != 0.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (bus.load) begin
            sr_d  = bus.x;
            cnt_d = CNT_W'(W);
        end else if (cnt_q != '0) begin
            sr_d  = {1'b0, sr_q[DATA_WIDTH-1:2]};
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.y    = sr_q;
    assign bus.z    = sr_q[1];
    assign bus.busy = (cnt_q != '0);
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed scenarios plus random traffic, every cycle
// compared against a word/shift-count reference model.
module tb_piso_serializer;
    localparam int DATA_WIDTH = 9;
    localparam int W          = DATA_WIDTH - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    piso_serializer_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

    piso_serializer #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    // Reference: the last loaded word and how many bits have been shifted out of it.
    logic [W-1:0] model_word;
    int           model_shifts;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
                     tag, cycle, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic load_v, input logic [W-1:0] x_v);
        logic [W-1:0] exp_y;
        logic         exp_busy;
        rst      = rst_v;
        bus.load = load_v;
        bus.x    = x_v;
        @(posedge clk);
        cycle++;
        if (rst_v) begin
            model_word   = '0;
            model_shifts = W;
        end else if (load_v) begin
            model_word   = x_v;
            model_shifts = 0;
        end else if (model_shifts < W) begin
            model_shifts++;
        end
        exp_y    = model_word >> model_shifts;
        exp_busy = (model_shifts < W);
        #1;
        checkOutput("y",    32'(bus.y),    32'(exp_y));
        checkOutput("z",    32'(bus.z),    32'(exp_y[0]));
        checkOutput("busy", 32'(bus.busy), 32'(exp_busy));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, W'($urandom));
    endtask

    initial begin
        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.x        = '1;
        model_word   = '0;
        model_shifts = W;

        applyStimulus(1'b1, 1'b0, '1);
        applyStimulus(1'b1, 1'b0, '1);
        applyStimulus(1'b0, 1'b0, '1);

        applyStimulus(1'b0, 1'b1, 8'hFF);
        idleCycles(10);

        applyStimulus(1'b0, 1'b1, 8'b1011_0010);
        idleCycles(10);

        applyStimulus(1'b0, 1'b1, 8'b1111_0000);
        idleCycles(3);
        applyStimulus(1'b0, 1'b1, 8'b0000_0001);
        idleCycles(10);

        applyStimulus(1'b0, 1'b1, 8'h11);
        applyStimulus(1'b0, 1'b1, 8'h22);
        applyStimulus(1'b0, 1'b1, 8'h33);
        applyStimulus(1'b1, 1'b1, 8'h5A);
        idleCycles(2);

        applyStimulus(1'b0, 1'b1, 8'b1010_1010);
        idleCycles(7);
        applyStimulus(1'b0, 1'b1, 8'b0101_0101);
        idleCycles(10);

        for (int i = 0; i < 400; i++)
            applyStimulus(($urandom_range(49) == 0), ($urandom_range(5) == 0), W'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
